// File: rtl/bot_io_bridge_if.sv
// KCPSM6 port bus bundled as one interface: address, data, strobes and interrupt handshake.
// The CPU side uses the master modport; the bridge uses slave.
interface bot_io_bridge_if;
   logic [7:0] PortID;
   logic [7:0] DataIn;
   logic [7:0] DataOut;
   logic       WriteStrobe;
   logic       ReadStrobe;
   logic       Interrupt;
   logic       InterruptAck;

   modport master (
      output PortID, DataIn, WriteStrobe, ReadStrobe, InterruptAck,
      input  DataOut, Interrupt
   );

   modport slave (
      input  PortID, DataIn, WriteStrobe, ReadStrobe, InterruptAck,
      output DataOut, Interrupt
   );
endinterface

// File: rtl/bot_io_bridge.sv
// Port-mapped bridge between KCPSM6 and NUM_BOTS RojoBot channels plus board I/O,
// with a latched, acked bot-update interrupt. Define BOTIF_SNAPSHOT_EN for CSR shadowing.
module bot_io_bridge #(
   parameter int unsigned NUM_BOTS  = 2,
   parameter logic [7:0]  BOT_BASE  = 8'h20,
   parameter logic [4:0]  DIG_BLANK = 5'h1F
) (
   input  logic                  clk,
   input  logic                  reset,
   bot_io_bridge_if.slave        bus,
   output logic [8*NUM_BOTS-1:0] MotCtl,
   input  logic [8*NUM_BOTS-1:0] LocX,
   input  logic [8*NUM_BOTS-1:0] LocY,
   input  logic [8*NUM_BOTS-1:0] BotInfo,
   input  logic [8*NUM_BOTS-1:0] Sensors,
   input  logic [NUM_BOTS-1:0]   BotUpd,
   output logic [39:0]           Dig,
   output logic [7:0]            DP,
   output logic [15:0]           LED,
   input  logic [4:0]            Button,
   input  logic [15:0]           Switch
);

   typedef enum logic {StIdle, StAssert} irq_st_e;

   irq_st_e               state_q, state_d;
   logic [8*NUM_BOTS-1:0] mot_q, mot_d;
   logic [15:0]           led_q, led_d;
   logic [7:0]            dp_q, dp_d;
   logic [39:0]           dig_q, dig_d;
   logic [7:0]            dout_q, dout_d;
   logic [NUM_BOTS-1:0]   pend_q, pend_d;
   logic [NUM_BOTS-1:0]   cause_q, cause_d;

   logic [8*NUM_BOTS-1:0] rd_locx, rd_locy, rd_info, rd_sens;

   // Bot window decode: offset from BOT_BASE, 8 ports per channel.
   logic [7:0] bot_off;
   logic       bot_hit;
   logic [1:0] bot_idx;
   logic [2:0] bot_reg;

   assign bot_off = bus.PortID - BOT_BASE;
   assign bot_hit = (bus.PortID >= BOT_BASE) && (bot_off < 8'(8 * NUM_BOTS));
   assign bot_idx = bot_off[4:3];
   assign bot_reg = bot_off[2:0];

`ifdef BOTIF_SNAPSHOT_EN
   logic [8*NUM_BOTS-1:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d;
   logic [8*NUM_BOTS-1:0] snap_i_q, snap_i_d, snap_s_q, snap_s_d;

   always_comb begin
      snap_x_d = snap_x_q;
      snap_y_d = snap_y_q;
      snap_i_d = snap_i_q;
      snap_s_d = snap_s_q;
      for (int i = 0; i < NUM_BOTS; i++) begin
         if (BotUpd[i]) begin
            snap_x_d[8*i +: 8] = LocX[8*i +: 8];
            snap_y_d[8*i +: 8] = LocY[8*i +: 8];
            snap_i_d[8*i +: 8] = BotInfo[8*i +: 8];
            snap_s_d[8*i +: 8] = Sensors[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_x_q <= '0;
         snap_y_q <= '0;
         snap_i_q <= '0;
         snap_s_q <= '0;
      end else begin
         snap_x_q <= snap_x_d;
         snap_y_q <= snap_y_d;
         snap_i_q <= snap_i_d;
         snap_s_q <= snap_s_d;
      end
   end

   assign rd_locx = snap_x_q;
   assign rd_locy = snap_y_q;
   assign rd_info = snap_i_q;
   assign rd_sens = snap_s_q;
`else
   assign rd_locx = LocX;
   assign rd_locy = LocY;
   assign rd_info = BotInfo;
   assign rd_sens = Sensors;
`endif

   // Read mux, registered into DataOut every cycle regardless of ReadStrobe.
   always_comb begin
      dout_d = '0;
      case (bus.PortID)
         8'h00:   dout_d = {3'b000, Button};
         8'h01:   dout_d = Switch[7:0];
         8'h02:   dout_d = Switch[15:8];
         8'h07:   dout_d[NUM_BOTS-1:0] = cause_q;
         default: ;
      endcase
      if (bot_hit) begin
         for (int i = 0; i < NUM_BOTS; i++) begin
            if (bot_idx == 2'(i)) begin
               case (bot_reg)
                  3'd0:    dout_d = rd_locx[8*i +: 8];
                  3'd1:    dout_d = rd_locy[8*i +: 8];
                  3'd2:    dout_d = rd_info[8*i +: 8];
                  3'd3:    dout_d = rd_sens[8*i +: 8];
                  3'd4:    dout_d = mot_q[8*i +: 8];
                  default: dout_d = '0;
               endcase
            end
         end
      end
   end

   always_comb begin
      mot_d = mot_q;
      led_d = led_q;
      dp_d  = dp_q;
      dig_d = dig_q;
      if (bus.WriteStrobe) begin
         case (bus.PortID)
            8'h01:   led_d[7:0]  = bus.DataIn;
            8'h02:   led_d[15:8] = bus.DataIn;
            8'h18:   dp_d        = bus.DataIn;
            default: ;
         endcase
         if (bus.PortID[7:3] == 5'b00010) begin
            for (int k = 0; k < 8; k++) begin
               if (bus.PortID[2:0] == 3'(k)) dig_d[5*k +: 5] = bus.DataIn[4:0];
            end
         end
         if (bot_hit && (bot_reg == 3'd0)) begin
            for (int i = 0; i < NUM_BOTS; i++) begin
               if (bot_idx == 2'(i)) mot_d[8*i +: 8] = bus.DataIn;
            end
         end
      end
   end

   // New update pulses always land in pending, even on the ack cycle.
   always_comb begin
      pend_d  = (bus.InterruptAck ? '0 : pend_q) | BotUpd;
      cause_d = cause_q;
      if (bus.InterruptAck) begin
         cause_d = pend_q;
      end else if (bus.ReadStrobe && (bus.PortID == 8'h07)) begin
         cause_d = '0;
      end
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (|pend_d) state_d = StAssert;
         StAssert: if (bus.InterruptAck) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         mot_q   <= '0;
         led_q   <= '0;
         dp_q    <= '0;
         dig_q   <= {8{DIG_BLANK}};
         dout_q  <= '0;
         pend_q  <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         mot_q   <= mot_d;
         led_q   <= led_d;
         dp_q    <= dp_d;
         dig_q   <= dig_d;
         dout_q  <= dout_d;
         pend_q  <= pend_d;
         cause_q <= cause_d;
      end
   end

   assign bus.DataOut   = dout_q;
   assign bus.Interrupt = (state_q == StAssert);
   assign MotCtl        = mot_q;
   assign LED           = led_q;
   assign DP            = dp_q;
   assign Dig           = dig_q;

endmodule

// File: tb/tb_bot_io_bridge.sv
// Randomized bench for bot_io_bridge: behavioural port-map/interrupt model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bot_io_bridge;
   localparam int unsigned NB = 2;
   localparam logic [7:0]  BB = 8'h20;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   bot_io_bridge_if bus();
   logic [8*NB-1:0] mot, locx, locy, info, sens;
   logic [NB-1:0]   upd;
   logic [39:0]     dig;
   logic [7:0]      dp;
   logic [15:0]     led;
   logic [4:0]      btn;
   logic [15:0]     sw;

   bot_io_bridge #(.NUM_BOTS(NB), .BOT_BASE(BB), .DIG_BLANK(5'h1F)) dut (
      .clk(clk), .reset(reset), .bus(bus), .MotCtl(mot), .LocX(locx), .LocY(locy),
      .BotInfo(info), .Sensors(sens), .BotUpd(upd), .Dig(dig), .DP(dp), .LED(led),
      .Button(btn), .Switch(sw)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   logic [7:0]    m_mot[NB];
   logic [15:0]   m_led;
   logic [7:0]    m_dp;
   logic [4:0]    m_dig[8];
   logic [NB-1:0] m_pend, m_cause;
   bit            m_irq;
   logic [7:0]    m_dout;
   logic [7:0]    m_sx[NB], m_sy[NB], m_si[NB], m_ss[NB];

   function automatic logic [7:0] csr(input int b, input int r);
`ifdef BOTIF_SNAPSHOT_EN
      case (r)
         0:       return m_sx[b];
         1:       return m_sy[b];
         2:       return m_si[b];
         default: return m_ss[b];
      endcase
`else
      case (r)
         0:       return locx[8*b +: 8];
         1:       return locy[8*b +: 8];
         2:       return info[8*b +: 8];
         default: return sens[8*b +: 8];
      endcase
`endif
   endfunction

   function automatic logic [7:0] mread(input logic [7:0] p);
      int off;
      logic [7:0] v;
      off = int'(p) - int'(BB);
      v = 8'h00;
      if (p == 8'h00) v = {3'b000, btn};
      else if (p == 8'h01) v = sw[7:0];
      else if (p == 8'h02) v = sw[15:8];
      else if (p == 8'h07) v = 8'(m_cause);
      if (off >= 0 && off < int'(8 * NB)) begin
         if (off % 8 < 4) v = csr(off / 8, off % 8);
         else if (off % 8 == 4) v = m_mot[off / 8];
         else v = 8'h00;
      end
      return v;
   endfunction

   always @(posedge clk or posedge reset) begin : model
      logic [NB-1:0] np;
      logic [7:0] p;
      bit ack;
      int off;
      if (reset) begin
         for (int b = 0; b < NB; b++) begin
            m_mot[b] = 0; m_sx[b] = 0; m_sy[b] = 0; m_si[b] = 0; m_ss[b] = 0;
         end
         for (int k = 0; k < 8; k++) m_dig[k] = 5'h1F;
         m_led = 0; m_dp = 0; m_pend = 0; m_cause = 0; m_irq = 0; m_dout = 0;
      end else begin
         p = bus.PortID;
         ack = bus.InterruptAck;
         m_dout = mread(p);
         if (bus.WriteStrobe) begin
            off = int'(p) - int'(BB);
            if (p == 8'h01) m_led[7:0] = bus.DataIn;
            if (p == 8'h02) m_led[15:8] = bus.DataIn;
            if (p >= 8'h10 && p <= 8'h17) m_dig[p - 8'h10] = bus.DataIn[4:0];
            if (p == 8'h18) m_dp = bus.DataIn;
            if (off >= 0 && off < int'(8 * NB) && off % 8 == 0) m_mot[off / 8] = bus.DataIn;
         end
         if (ack) m_cause = m_pend;
         else if (bus.ReadStrobe && p == 8'h07) m_cause = 0;
         np = (ack ? '0 : m_pend) | upd;
         m_irq = m_irq ? !ack : (np != 0);
         m_pend = np;
         for (int b = 0; b < NB; b++) begin
            if (upd[b]) begin
               m_sx[b] = locx[8*b +: 8]; m_sy[b] = locy[8*b +: 8];
               m_si[b] = info[8*b +: 8]; m_ss[b] = sens[8*b +: 8];
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [8*NB-1:0] em;
      logic [39:0] ed;
      for (int b = 0; b < NB; b++) em[8*b +: 8] = m_mot[b];
      for (int k = 0; k < 8; k++) ed[5*k +: 5] = m_dig[k];
      chk("DataOut", bus.DataOut, m_dout);
      chk("Interrupt", bus.Interrupt, m_irq);
      chk("MotCtl", mot, em);
      chk("LED", led, m_led);
      chk("DP", dp, m_dp);
      chk("Dig", dig, ed);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [7:0] p, input logic [7:0] d);
      bus.PortID = p; bus.DataIn = d; bus.WriteStrobe = 1'b1;
      tick();
      bus.WriteStrobe = 1'b0;
   endtask

   task automatic rd(input logic [7:0] p, input bit strobe, output logic [7:0] v);
      bus.PortID = p; bus.ReadStrobe = strobe;
      tick();
      bus.ReadStrobe = 1'b0;
      v = bus.DataOut;
   endtask

   task automatic rand_cycle();
      case ($urandom_range(0, 5))
         0:       bus.PortID = 8'($urandom_range(0, 3));
         1:       bus.PortID = 8'h07;
         2:       bus.PortID = 8'h10 + 8'($urandom_range(0, 8));
         3, 4:    bus.PortID = BB + 8'($urandom_range(0, 23));
         default: bus.PortID = 8'($urandom);
      endcase
      bus.DataIn = 8'($urandom);
      bus.WriteStrobe = ($urandom_range(0, 9) < 3);
      bus.ReadStrobe  = ($urandom_range(0, 9) < 3);
      for (int b = 0; b < NB; b++) upd[b] = ($urandom_range(0, 9) == 0);
      bus.InterruptAck = bus.Interrupt ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 4) == 0) begin
         locx = (8*NB)'($urandom); locy = (8*NB)'($urandom);
         info = (8*NB)'($urandom); sens = (8*NB)'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
         btn = 5'($urandom); sw = 16'($urandom);
      end
      tick();
   endtask

   task automatic quiet();
      bus.WriteStrobe = 0; bus.ReadStrobe = 0; bus.InterruptAck = 0; upd = 0;
   endtask

   logic [7:0] v;

   initial begin
      bus.PortID = 0; bus.DataIn = 0; bus.WriteStrobe = 0; bus.ReadStrobe = 0;
      bus.InterruptAck = 0; upd = 0;
      locx = 16'h3412; locy = 16'h7856; info = 16'hBC9A; sens = 16'hF0DE;
      btn = 5'h15; sw = 16'hC33C;
      #1 reset = 1'b1;
      repeat (2) tick();
      chk("reset_dig", dig, {8{5'h1F}});
      chk("reset_irq", bus.Interrupt, 0);
      reset = 1'b0;
      tick();

      // MotCtl write on bot 1 and readback
      wr(BB + 8'd8, 8'hA5);
      chk("mot1_write", mot, 16'hA500);
      rd(BB + 8'd12, 0, v);
      chk("mot1_readback", v, 8'hA5);
      rd(8'h00, 0, v);
      chk("button_read", v, 8'h15);
      rd(8'h02, 0, v);
      chk("switch_hi", v, 8'hC3);

      // Single update on bot 1, acked three cycles after the pulse
      upd = 2'b10; tick(); upd = 0;
      chk("irq_rise", bus.Interrupt, 1);
      tick(); tick();
      bus.InterruptAck = 1; tick(); bus.InterruptAck = 0;
      chk("irq_drop", bus.Interrupt, 0);
      rd(8'h07, 1, v);
      chk("cause_first", v, 8'h02);
      rd(8'h07, 1, v);
      chk("cause_second", v, 8'h00);

      // Bot 0 update coincident with ack of bot 1
      upd = 2'b10; tick(); upd = 0; tick();
      bus.InterruptAck = 1; upd = 2'b01; tick();
      bus.InterruptAck = 0; upd = 0;
      chk("irq_gap", bus.Interrupt, 0);
      bus.PortID = 8'h07; bus.ReadStrobe = 1; tick(); bus.ReadStrobe = 0;
      chk("cause_coinc", bus.DataOut, 8'h02);
      chk("irq_reassert", bus.Interrupt, 1);
      bus.InterruptAck = 1; tick(); bus.InterruptAck = 0;
      rd(8'h07, 1, v);
      chk("cause_next", v, 8'h01);

      // Snapshot versus live CSR read
      locx[7:0] = 8'h10; upd = 2'b01; tick(); upd = 0; locx[7:0] = 8'h20;
      rd(BB, 0, v);
`ifdef BOTIF_SNAPSHOT_EN
      chk("locx_snapshot", v, 8'h10);
`else
      chk("locx_live", v, 8'h20);
`endif
      bus.InterruptAck = 1; tick(); bus.InterruptAck = 0;

      // Unmapped ports read zero and ignore writes
      rd(8'h03, 0, v);       chk("unmapped_03", v, 8'h00);
      rd(8'h19, 0, v);       chk("unmapped_19", v, 8'h00);
      rd(BB + 8'd16, 0, v);  chk("bot2_read", v, 8'h00);
      wr(8'h03, 8'hFF); wr(8'h19, 8'hFF); wr(BB + 8'd16, 8'hFF);
      chk("unmapped_mot", mot, 16'hA500);
      chk("unmapped_led", led, 16'h0000);
      chk("unmapped_dp", dp, 8'h00);

      wr(8'h13, 8'h07); chk("dig3_write", dig[19:15], 5'h07);
      wr(8'h18, 8'h81); chk("dp_write", dp, 8'h81);
      wr(8'h01, 8'h5A); chk("led_write", led, 16'h005A);

      repeat (1500) rand_cycle();

      // Reset mid-run with an update pulse that must be lost
      quiet();
      wr(8'h02, 8'hC0);
      #2 reset = 1'b1; upd = 2'b11;
      #1;
      chk("midrst_mot", mot, 0);
      chk("midrst_led", led, 0);
      chk("midrst_dig", dig, {8{5'h1F}});
      chk("midrst_irq", bus.Interrupt, 0);
      chk("midrst_dout", bus.DataOut, 0);
      tick(); tick();
      upd = 0; reset = 1'b0;
      tick(); tick();
      chk("pulse_lost", bus.Interrupt, 0);

      repeat (400) rand_cycle();
      quiet();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
